alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Issue stage directly upstream of the ALU. Accepts decoded instructions over valid/ready and reads
//  operands from an internal 2R1W register file. Blocks RAW/WAW hazards with a per-register
//  pending scoreboard. Presents registered operands dtA/dtB and op code to the combinational ALU.
//  ALU results come back through the writeback port from the downstream stage.
// PARAMETERS
//  NREGS  16  number of architectural registers; R0 reads 0 and is never written or marked pending
//  DW     32  operand/data width; must equal ALU width
// PORTS
//  clk_i         in   1             single clock, rising edge
//  rst_ni        in   1             asynchronous, active-low reset
//  in_valid_i    in   1             decoded instruction valid
//  in_ready_o    out  1             stage accepts instruction this cycle
//  in_op_i       in   3             ALU op code (alu_op_e)
//  in_rs1_i      in   $clog2(NREGS) source A register
//  in_rs2_i      in   $clog2(NREGS) source B register (ignored when in_use_imm_i=1)
//  in_rd_i       in   $clog2(NREGS) destination register
//  in_wr_i       in   1             instruction writes rd
//  in_use_imm_i  in   1             operand B = in_imm_i instead of R[rs2]
//  in_imm_i      in   DW            immediate
//  ex_valid_o    out  1             operands valid toward ALU/downstream
//  ex_ready_i    in   1             downstream consumes current ex_* contents
//  dtA_o/dtB_o   out  DW            ALU operands
//  alu_op_o      out  3             ALU op code
//  ex_rd_o       out  $clog2(NREGS) destination tag carried with result
//  ex_wr_o       out  1             writeback required
//  wb_en_i       in   1             writeback strobe from downstream
//  wb_addr_i     in   $clog2(NREGS) writeback register
//  wb_data_i     in   DW            writeback data (alu_dt_o of retired op)
// BEHAVIOUR
//  Reset: all ex_* outputs 0. Scoreboard cleared. All registers 0. in_ready_o=1 after reset.
//  Reset mid-operation drops the in-flight instruction. Pending bits clear, and a later wb_en_i still
//    writes the regfile.
//  Regfile: synchronous write on wb_en_i when wb_addr_i!=0. Reads are combinational. R0 always reads 0.
//  Scoreboard pend[r]: set on accept when in_wr_i & rd!=0. Cleared on wb_en_i to r.
//    If set and clear hit the same register in the same cycle, set wins.
//  Hazard: (pend[rs1]) | (!in_use_imm_i & pend[rs2]) | (in_wr_i & pend[rd]), evaluating each
//    pend[x] as "effectively clear" only per CONFIGURATION rule. Sources equal to R0 are never hazards.
//  in_ready_o = !hazard & (!ex_valid_o | ex_ready_i). Accept = in_valid_i & in_ready_o.
//  Latency: accept in cycle N -> ex_* valid from cycle N+1. Throughput is 1/cycle without hazards.
//  ex_* hold stable while ex_valid_o & !ex_ready_i.
//  On ex_ready_i & !accept: ex_valid_o -> 0 and data is held.
//  The in_valid_i / in_* signals do not need to be held stable while in_ready_o=0.
//  Widths: operands DW bits. No sign/zero extension is applied to in_imm_i (already DW).
// CONFIGURATION
//  `ALU_WB_BYPASS_EN defined: when wb_en_i & wb_addr_i==rsX in the accept cycle, operand X takes
//    wb_data_i and pend[rsX] counts as clear. The same rule applies to rd for the WAW check.
//    This allows back-to-back dependent issue with a 0-cycle bubble after writeback.
//  Not defined: no bypass. An operand whose register is written this cycle stalls one cycle and is
//    read from the regfile on the next cycle.
// STRUCTURE
//  Package alu_pkg holds:
//    - typedef enum alu_op_e: ADD=0, SUB=1, ABS=2, SHL=3, AND=4, OR=5, XOR=6, NEG=7
//    - localparam DW=32, NREGS=16
//    - typedef reg_addr_t
//  Sub-module reg_file_2r1w: register array, R0 hardwire, optional bypass mux.
//  Scoreboard, hazard logic and the output register live in this top.
// TESTING
//  1 Reset: assert rst_ni=0 asynchronously mid-cycle -> ex_valid_o=0 immediately, all pend=0,
//    R1..R15 read 0.
//  2 Stream: wb R1=5, R2=3. Issue ADD r3<-r1,r2 then SUB r4<-r1,r2 with ex_ready_i=1 ->
//    dtA/dtB = 5/3 on consecutive cycles. Ops 000 then 001. No stall.
//  3 RAW: issue ADD r3<-r1,r2, then XOR r5<-r3,imm 0xFF. Second op stalls (in_ready_o=0) until
//    wb_en_i r3=8. With BYPASS: accepted in the wb cycle with dtA_o=8. Without: accepted 1 cycle later.
//  4 Backpressure: ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> ex_* stable and in_ready_o=0.
//    Release -> next instruction appears the next cycle.
//  5 WAW + same-cycle set/clear: r6 pending, issue wr r6 in the wb cycle for r6 (BYPASS) ->
//    pend[r6] stays 1.
//  6 R0: issue ADD r0<-r0,imm 7 -> dtA_o=0, no pend set. wb to r0 with 0xDEAD -> R0 still reads 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/issue stage.
// Holds the ALU op encoding, default widths and the register address type.
package alu_pkg;

    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        ABS = 3'd2,
        SHL = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        NEG = 3'd7
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file for the operand stage.
// R0 is hardwired to zero: writes to it are dropped and reads return 0.
// Reads are combinational; the write lands on the next rising edge.
// Optional feature: `ALU_WB_BYPASS_EN forwards the write data to a read port
// whose address matches the write address in the same cycle.
module reg_file_2r1w #(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(NREGS)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic [$clog2(NREGS)-1:0] raddr_a_i,
    input  logic [$clog2(NREGS)-1:0] raddr_b_i,
    output logic [DW-1:0]            rdata_a_o,
    output logic [DW-1:0]            rdata_b_o
);
    import alu_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [DW-1:0] regs [NREGS];
    logic          wr_live;

    // A write to R0 is architecturally a no-op.
    assign wr_live = we_i && (waddr_i != '0);

    // Register array: cleared on reset, written by the writeback port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    // Read port A: R0 reads zero, otherwise array (or forwarded write data).
    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != '0) begin
            rdata_a_o = regs[raddr_a_i];
        end
`ifdef ALU_WB_BYPASS_EN
        if (wr_live && (waddr_i == raddr_a_i)) begin
            rdata_a_o = wdata_i;
        end
`endif
    end

    // Read port B: same rules as port A.
    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != '0) begin
            rdata_b_o = regs[raddr_b_i];
        end
`ifdef ALU_WB_BYPASS_EN
        if (wr_live && (waddr_i == raddr_b_i)) begin
            rdata_b_o = wdata_i;
        end
`endif
    end

endmodule : reg_file_2r1w

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the combinational ALU.
// Accepts decoded instructions, reads operands from reg_file_2r1w, blocks
// RAW/WAW hazards with a per-register pending scoreboard and registers the
// operands, op code and destination tag toward the ALU.
// Optional feature: `ALU_WB_BYPASS_EN lets a writeback arriving in the accept
// cycle satisfy a pending source/destination and supplies its data directly.
//
// Handshake (both ports): a transfer happens on a rising edge where valid and
// ready are both 1. The upstream side may drop or change in_* while
// in_ready_o=0. The ex_* side holds all ex_* outputs stable while
// ex_valid_o=1 and ex_ready_i=0.
//
// pend_o exposes the scoreboard for observation; bit 0 is always 0.
module alu_operand_stage #(
    parameter int NREGS = 16,
    parameter int DW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // decoded instruction in
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [2:0]               in_op_i,
    input  logic [$clog2(NREGS)-1:0] in_rs1_i,
    input  logic [$clog2(NREGS)-1:0] in_rs2_i,
    input  logic [$clog2(NREGS)-1:0] in_rd_i,
    input  logic                     in_wr_i,
    input  logic                     in_use_imm_i,
    input  logic [DW-1:0]            in_imm_i,
    // operands toward the ALU / downstream
    output logic                     ex_valid_o,
    input  logic                     ex_ready_i,
    output logic [DW-1:0]            dtA_o,
    output logic [DW-1:0]            dtB_o,
    output logic [2:0]               alu_op_o,
    output logic [$clog2(NREGS)-1:0] ex_rd_o,
    output logic                     ex_wr_o,
    // writeback from downstream
    input  logic                     wb_en_i,
    input  logic [$clog2(NREGS)-1:0] wb_addr_i,
    input  logic [DW-1:0]            wb_data_i,
    // scoreboard observation
    output logic [NREGS-1:0]         pend_o
);
    import alu_pkg::*;

    localparam int AW = $clog2(NREGS);

    // scoreboard
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // hazard / handshake
    logic             wb_live;
    logic             rs1_busy;
    logic             rs2_busy;
    logic             rd_busy;
    logic             hazard;
    logic             accept;

    // register file read data
    logic [DW-1:0]    rdata_a;
    logic [DW-1:0]    rdata_b;
    logic [DW-1:0]    operand_b;

    // output register
    logic             ex_valid_q;
    logic [DW-1:0]    dta_q;
    logic [DW-1:0]    dtb_q;
    alu_op_e          op_q;
    logic [AW-1:0]    rd_q;
    logic             wr_q;

    reg_file_2r1w #(
        .NREGS (NREGS),
        .DW    (DW)
    ) u_reg_file (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (wb_en_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i),
        .raddr_a_i (in_rs1_i),
        .raddr_b_i (in_rs2_i),
        .rdata_a_o (rdata_a),
        .rdata_b_o (rdata_b)
    );

    // Writebacks to R0 never touch state.
    assign wb_live = wb_en_i && (wb_addr_i != '0);

    // Per-register busy flags; R0 is never busy. With the bypass, a
    // writeback to the same register in this cycle resolves the dependency.
    always_comb begin
        rs1_busy = (in_rs1_i != '0) && pend_q[in_rs1_i];
        rs2_busy = (in_rs2_i != '0) && pend_q[in_rs2_i];
        rd_busy  = (in_rd_i  != '0) && pend_q[in_rd_i];
`ifdef ALU_WB_BYPASS_EN
        if (wb_live && (wb_addr_i == in_rs1_i)) rs1_busy = 1'b0;
        if (wb_live && (wb_addr_i == in_rs2_i)) rs2_busy = 1'b0;
        if (wb_live && (wb_addr_i == in_rd_i))  rd_busy  = 1'b0;
`endif
    end

    // Source B only matters when it is a register; rd only when it is written.
    assign hazard     = rs1_busy || (!in_use_imm_i && rs2_busy) || (in_wr_i && rd_busy);
    assign in_ready_o = !hazard && (!ex_valid_o || ex_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    // Scoreboard update: writeback clears, accept of a writing op sets.
    // The set is applied last so it wins on a same-register collision.
    always_comb begin
        pend_d = pend_q;
        if (wb_live) begin
            pend_d[wb_addr_i] = 1'b0;
        end
        if (accept && in_wr_i && (in_rd_i != '0)) begin
            pend_d[in_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Immediate is already full width; no extension.
    assign operand_b = in_use_imm_i ? in_imm_i : rdata_b;

    // Output register: load on accept, drop valid when drained, else hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q <= 1'b0;
            dta_q      <= '0;
            dtb_q      <= '0;
            op_q       <= ADD;
            rd_q       <= '0;
            wr_q       <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            dta_q      <= rdata_a;
            dtb_q      <= operand_b;
            op_q       <= alu_op_e'(in_op_i);
            rd_q       <= in_rd_i;
            wr_q       <= in_wr_i;
        end else if (ex_ready_i) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign dtA_o      = dta_q;
    assign dtB_o      = dtb_q;
    assign alu_op_o   = op_q;
    assign ex_rd_o    = rd_q;
    assign ex_wr_o    = wr_q;
    assign pend_o     = pend_q;

endmodule : alu_operand_stage

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage.
// Reference model: architectural register array, pending set and a single
// expected ex_* slot, updated from the stated issue/writeback rules. A
// downstream model turns retired writing ops into writebacks kept in exp_q.
// Honors `ALU_WB_BYPASS_EN the same way the design does.
module tb_alu_operand_stage;

    localparam int DW    = 32;
    localparam int NREGS = 16;
    localparam int AW    = 4;
`ifdef ALU_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready_o;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic [AW-1:0]    in_rd;
    logic             in_wr;
    logic             in_use_imm;
    logic [DW-1:0]    in_imm;
    logic             ex_valid_o;
    logic             ex_ready;
    logic [DW-1:0]    dtA_o;
    logic [DW-1:0]    dtB_o;
    logic [2:0]       alu_op_o;
    logic [AW-1:0]    ex_rd_o;
    logic             ex_wr_o;
    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [DW-1:0]    wb_data;
    logic [NREGS-1:0] pend_o;

    alu_operand_stage #(
        .NREGS (NREGS),
        .DW    (DW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .in_op_i      (in_op),
        .in_rs1_i     (in_rs1),
        .in_rs2_i     (in_rs2),
        .in_rd_i      (in_rd),
        .in_wr_i      (in_wr),
        .in_use_imm_i (in_use_imm),
        .in_imm_i     (in_imm),
        .ex_valid_o   (ex_valid_o),
        .ex_ready_i   (ex_ready),
        .dtA_o        (dtA_o),
        .dtB_o        (dtB_o),
        .alu_op_o     (alu_op_o),
        .ex_rd_o      (ex_rd_o),
        .ex_wr_o      (ex_wr_o),
        .wb_en_i      (wb_en),
        .wb_addr_i    (wb_addr),
        .wb_data_i    (wb_data),
        .pend_o       (pend_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0]       m_regs [NREGS];
    bit                  m_pend [NREGS];
    bit                  m_ex_valid;
    logic [DW-1:0]       m_ex_a;
    logic [DW-1:0]       m_ex_b;
    logic [2:0]          m_ex_op;
    logic [AW-1:0]       m_ex_rd;
    bit                  m_ex_wr;
    bit                  m_acc;
    bit                  wb_from_q;
    // pending writebacks of retired ops: {rd, result}
    logic [AW+DW-1:0]    exp_q [$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_ex_valid = 1'b0;
        m_ex_a     = '0;
        m_ex_b     = '0;
        m_ex_op    = '0;
        m_ex_rd    = '0;
        m_ex_wr    = 1'b0;
        m_acc      = 1'b0;
        exp_q.delete();
    endtask

    function automatic bit eff_pend(logic [AW-1:0] r);
        if (r == '0) return 1'b0;
        if (BYPASS && wb_en && wb_addr == r) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic logic [DW-1:0] read_val(logic [AW-1:0] r);
        if (r == '0) return '0;
        if (BYPASS && wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic [DW-1:0] alu_ref(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a[DW-1] ? -a : a;
            3'd3: return a << b[4:0];
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return -a;
        endcase
    endfunction

    // One clock: compare at the falling edge, advance the model, return
    // 1 time unit after the next rising edge so new stimulus can be driven.
    task automatic tick();
        bit               exp_ready;
        bit               acc;
        logic [NREGS-1:0] pv;
        @(negedge clk);
        exp_ready = !(eff_pend(in_rs1) || (!in_use_imm && eff_pend(in_rs2)) ||
                      (in_wr && eff_pend(in_rd))) && (!m_ex_valid || ex_ready);
        check("in_ready", 64'(in_ready_o), 64'(exp_ready));
        check("ex_valid", 64'(ex_valid_o), 64'(m_ex_valid));
        if (m_ex_valid) begin
            check("dtA", 64'(dtA_o), 64'(m_ex_a));
            check("dtB", 64'(dtB_o), 64'(m_ex_b));
            check("alu_op", 64'(alu_op_o), 64'(m_ex_op));
            check("ex_rd", 64'(ex_rd_o), 64'(m_ex_rd));
            check("ex_wr", 64'(ex_wr_o), 64'(m_ex_wr));
        end
        for (int i = 0; i < NREGS; i++) pv[i] = m_pend[i];
        check("pend", 64'(pend_o), 64'(pv));
        acc = in_valid && exp_ready;
        // downstream retires the current ex contents
        if (m_ex_valid && ex_ready && m_ex_wr && m_ex_rd != '0)
            exp_q.push_back({m_ex_rd, alu_ref(m_ex_op, m_ex_a, m_ex_b)});
        if (acc) begin
            m_ex_valid = 1'b1;
            m_ex_a     = read_val(in_rs1);
            m_ex_b     = in_use_imm ? in_imm : read_val(in_rs2);
            m_ex_op    = in_op;
            m_ex_rd    = in_rd;
            m_ex_wr    = in_wr;
        end else if (ex_ready) begin
            m_ex_valid = 1'b0;
        end
        if (wb_en && wb_addr != '0) begin
            m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (wb_en && wb_from_q) void'(exp_q.pop_front());
        if (acc && in_wr && in_rd != '0) m_pend[in_rd] = 1'b1;
        m_acc = acc;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_insn(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                              input logic [AW-1:0] rd, input logic wr, input logic use_imm,
                              input logic [DW-1:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_wr      = wr;
        in_use_imm = use_imm;
        in_imm     = imm;
    endtask

    task automatic wb_none();
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        wb_from_q = 1'b0;
    endtask

    task automatic wb_head();
        wb_none();
        if (exp_q.size() > 0) begin
            {wb_addr, wb_data} = exp_q[0];
            wb_en     = 1'b1;
            wb_from_q = 1'b1;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        ex_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wb_head();
            tick();
        end
        wb_none();
        check("drain_pend", 64'(pend_o), 64'(0));
    endtask

    task automatic drive_random();
        in_valid   = ($urandom_range(0, 9) < 8);
        in_op      = 3'($urandom_range(0, 7));
        in_rs1     = AW'($urandom_range(0, 7));
        in_rs2     = AW'($urandom_range(0, 7));
        in_rd      = AW'($urandom_range(0, 7));
        in_wr      = ($urandom_range(0, 3) != 0);
        in_use_imm = ($urandom_range(0, 1) != 0);
        in_imm     = DW'($urandom);
        ex_ready   = ($urandom_range(0, 9) < 7);
        wb_none();
        if (exp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            wb_head();
        end else if ($urandom_range(0, 15) == 0) begin
            wb_en   = 1'b1;
            wb_addr = '0;
            wb_data = 32'hDEAD;
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        in_valid = 1'b0;
        ex_ready = 1'b0;
        wb_none();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ex_valid", 64'(ex_valid_o), 64'(0));
        check("rst_pend", 64'(pend_o), 64'(0));
        check("rst_in_ready", 64'(in_ready_o), 64'(1));
        check("rst_dtA", 64'(dtA_o), 64'(0));
        check("rst_ex_wr", 64'(ex_wr_o), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tries;
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_wr = 1'b0; in_use_imm = 1'b0; in_imm = '0; ex_ready = 1'b0;
        wb_none();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ex_valid", 64'(ex_valid_o), 64'(0));
        check("reset_pend", 64'(pend_o), 64'(0));
        check("reset_alu_op", 64'(alu_op_o), 64'(0));
        check("reset_in_ready", 64'(in_ready_o), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // every register reads zero after reset
        ex_ready = 1'b1;
        for (int r = 1; r < NREGS; r++) begin
            drive_insn(3'd0, AW'(r), AW'(r), '0, 1'b0, 1'b1, 32'h0);
            tick();
            check("r_zero_dtA", 64'(dtA_o), 64'(0));
        end
        in_valid = 1'b0;
        tick();

        // stream: R1=5, R2=3, then ADD and SUB back to back
        wb_en = 1'b1; wb_addr = 4'd1; wb_data = 32'd5; tick();
        wb_addr = 4'd2; wb_data = 32'd3; tick();
        wb_none();
        drive_insn(3'd0, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 32'h0);
        tick();
        check("stream_add_dtA", 64'(dtA_o), 64'd5);
        check("stream_add_dtB", 64'(dtB_o), 64'd3);
        check("stream_add_op", 64'(alu_op_o), 64'd0);
        drive_insn(3'd1, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 32'h0);
        tick();
        check("stream_sub_dtA", 64'(dtA_o), 64'd5);
        check("stream_sub_dtB", 64'(dtB_o), 64'd3);
        check("stream_sub_op", 64'(alu_op_o), 64'd1);

        // RAW: XOR r5 <- r3, imm 0xFF (rs2=r4 is pending but ignored)
        drive_insn(3'd6, 4'd3, 4'd4, 4'd5, 1'b1, 1'b1, 32'hFF);
        tick();
        check("raw_stall0", 64'(in_ready_o), 64'd0);
        tick();
        check("raw_stall1", 64'(in_ready_o), 64'd0);
        wb_head();
        check("raw_wb_is_r3", 64'(wb_addr), 64'd3);
        check("raw_wb_val", 64'(wb_data), 64'd8);
        tries = 0;
        for (int i = 0; i < 3; i++) begin
            tries++;
            tick();
            wb_none();
            if (m_acc) break;
        end
        in_valid = 1'b0;
        check("raw_latency", 64'(tries), BYPASS ? 64'd1 : 64'd2);
        check("raw_dtA", 64'(dtA_o), 64'd8);
        check("raw_dtB", 64'(dtB_o), 64'hFF);
        check("raw_op", 64'(alu_op_o), 64'd6);
        drain();

        // backpressure: AND held for 3 cycles, OR waits behind it
        drive_insn(3'd4, 4'd1, 4'd2, 4'd7, 1'b1, 1'b0, 32'h0);
        tick();
        ex_ready = 1'b0;
        drive_insn(3'd5, 4'd1, 4'd0, 4'd8, 1'b1, 1'b1, 32'h30);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 64'(ex_valid_o), 64'd1);
            check("bp_op", 64'(alu_op_o), 64'd4);
            check("bp_ready", 64'(in_ready_o), 64'd0);
        end
        ex_ready = 1'b1;
        tick();
        check("bp_next_op", 64'(alu_op_o), 64'd5);
        check("bp_next_dtB", 64'(dtB_o), 64'h30);
        drain();

        // WAW with same-cycle set/clear on r6
        drive_insn(3'd0, 4'd1, 4'd0, 4'd6, 1'b1, 1'b1, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        drive_insn(3'd1, 4'd2, 4'd1, 4'd6, 1'b1, 1'b0, 32'h0);
        wb_head();
        check("waw_wb_is_r6", 64'(wb_addr), 64'd6);
        tries = 0;
        for (int i = 0; i < 3; i++) begin
            tries++;
            tick();
            wb_none();
            if (m_acc) break;
        end
        in_valid = 1'b0;
        check("waw_latency", 64'(tries), BYPASS ? 64'd1 : 64'd2);
        check("waw_pend6", 64'(pend_o[6]), 64'd1);
        drain();

        // R0: write 0xDEAD to r0 while issuing ADD r0 <- r0, imm 7
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hDEAD;
        drive_insn(3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'd7);
        tick();
        wb_none();
        check("r0_dtA", 64'(dtA_o), 64'd0);
        check("r0_dtB", 64'(dtB_o), 64'd7);
        check("r0_pend", 64'(pend_o), 64'd0);
        tick();
        check("r0_dtA_again", 64'(dtA_o), 64'd0);
        drain();

        // randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset();
            drive_random();
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_alu_operand_stage
